// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, clocks one command byte out
// on device-generated clock edges, and reports the device ack as tx_done or tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       keyclk_in,
    input  logic       keyinput_in,
    output logic       keyclk_oe,
    output logic       keyinput_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;

    state_t           state_q;
    logic [1:0]       kclk_sync_q, kdat_sync_q;
    logic             kclk_prev_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [3:0]       bit_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             keyclk_oe_q, keyinput_oe_q, tx_ready_q, busy_q, tx_done_q, tx_err_q;

    logic kclk_s, kdat_s, kclk_fe;
    assign kclk_s  = kclk_sync_q[1];
    assign kdat_s  = kdat_sync_q[1];
    assign kclk_fe = kclk_prev_q & ~kclk_s;

    // Synchronizers reset to the idle (pulled-up) bus level so no false edge follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kclk_sync_q <= 2'b11;
            kdat_sync_q <= 2'b11;
            kclk_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain really is two stages.
            kclk_sync_q <= {kclk_sync_q[0], keyclk_in};
            kdat_sync_q <= {kdat_sync_q[0], keyinput_in};
            kclk_prev_q <= kclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            bit_idx_q     <= '0;
            cnt_q         <= '0;
            keyclk_oe_q   <= 1'b0;
            keyinput_oe_q <= 1'b0;
            tx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_err_q      <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_q       <= tx_data;
                        parity_q      <= ~^tx_data;
                        bit_idx_q     <= '0;
                        cnt_q         <= '0;
                        keyclk_oe_q   <= 1'b1;
                        keyinput_oe_q <= (INHIBIT_CYCLES == 1);
                        tx_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        keyclk_oe_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= SEND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == INH_DATA) keyinput_oe_q <= 1'b1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    // Timeout wins over a clock edge arriving in the same cycle.
                    if (cnt_q == TO_LAST) begin
                        keyclk_oe_q   <= 1'b0;
                        keyinput_oe_q <= 1'b0;
                        tx_err_q      <= 1'b1;
                        tx_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (state_q == SEND && kclk_fe) begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            if (bit_idx_q < 4'd8) begin
                                keyinput_oe_q <= ~shift_q[0];
                                shift_q       <= shift_q >> 1;
                            end else if (bit_idx_q == 4'd8) begin
                                keyinput_oe_q <= ~parity_q;
                            end else begin
                                keyinput_oe_q <= 1'b0;
                                state_q       <= ACK;
                            end
                        end else if (state_q == ACK && kclk_fe) begin
                            if (!kdat_s) begin
                                state_q <= WAIT_IDLE;
                            end else begin
                                tx_err_q   <= 1'b1;
                                tx_ready_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else if (state_q == WAIT_IDLE && kclk_s && kdat_s) begin
                            tx_done_q  <= 1'b1;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    keyclk_oe_q   <= 1'b0;
                    keyinput_oe_q <= 1'b0;
                    tx_ready_q    <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign keyclk_oe   = keyclk_oe_q;
    assign keyinput_oe = keyinput_oe_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// scoreboard pairs each completion pulse with the response predicted from the command byte.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 4000;
    localparam int HALF = 100;

    typedef enum {M_ACK, M_NOACK, M_SILENT, M_ABORT} mode_t;
    typedef struct {
        bit          is_err;
        bit          chk_frame;
        bit          chk_delay;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, keyclk_oe, keyinput_oe, busy, tx_done, tx_err;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    logic       keyclk_line, keyinput_line;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          send_cyc = 0;
    logic [10:0] dev_frame = '0;
    exp_t        exp_q[$];

    assign keyclk_line   = ~(keyclk_oe | dev_clk_low);
    assign keyinput_line = ~(keyinput_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .keyclk_in   (keyclk_line),
        .keyinput_in (keyinput_line),
        .keyclk_oe   (keyclk_oe),
        .keyinput_oe (keyinput_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Line order as the device reads it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (tx_done || tx_err)) begin
                check("pulse_exclusive", {31'd0, tx_done & tx_err}, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: done=%b err=%b, want no pulse", tx_done, tx_err);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_err", tx_err, e.is_err);
                    check("pulse_done", tx_done, !e.is_err);
                    check("ready_with_pulse", {busy, tx_ready}, 2'b01);
                    check("lines_released", {keyclk_oe, keyinput_oe}, 2'b00);
                    if (e.chk_frame) check("frame", dev_frame, e.frame);
                    if (e.chk_delay) check("timeout_delay", cyc - send_cyc, TO);
                end
            end
        end
    end

    task automatic device(input mode_t mode);
        int n = 0;
        int first_kio = 0;
        for (int i = 0; i < 10 && !keyclk_oe; i++) @(negedge clk);
        while (keyclk_oe && n < 200) begin
            n++;
            if (keyinput_oe && first_kio == 0) first_kio = n;
            @(negedge clk);
        end
        send_cyc = cyc;
        check("inhibit_len", n, INH);
        check("start_low_cycle", first_kio, INH);
        check("start_held", keyinput_oe, 1);
        if (mode == M_SILENT) return;
        for (int i = 0; i < 11; i++) begin
            repeat (HALF / 2) @(negedge clk);
            dev_frame[i] = keyinput_line;
            if (i == 10 && mode == M_ACK) dev_dat_low = 1'b1;
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            if (mode == M_ABORT && i == 4) begin
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b0;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (mode == M_ACK) begin
            repeat (HALF / 2) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic injector();
        bit saw_ready = 1'b0;
        repeat (300) @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (tx_ready || !busy) saw_ready = 1'b1;
        end
        tx_valid = 1'b0;
        check("ready_low_while_busy", saw_ready, 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input mode_t mode, input bit inject);
        exp_t e;
        int   k = 0;
        for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
        check("ready_before_send", tx_ready, 1);
        e.frame     = ref_frame(d);
        e.is_err    = (mode != M_ACK);
        e.chk_frame = (mode == M_ACK || mode == M_NOACK);
        e.chk_delay = (mode == M_SILENT);
        if (mode != M_ABORT) exp_q.push_back(e);
        dev_frame = '0;
        tx_data   = d;
        tx_valid  = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", {busy, tx_ready}, 2'b10);
        if (inject) begin
            fork
                device(mode);
                injector();
            join
        end else begin
            device(mode);
        end
        if (mode == M_ABORT) return;
        while (busy && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check("frame_finished", busy, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] r;
        bit         idle_moved = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {keyclk_oe, keyinput_oe, tx_ready, busy, tx_done, tx_err}, 6'b001000);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            dev_clk_low = 1'($urandom);
            dev_dat_low = 1'($urandom);
            repeat (10) begin
                @(negedge clk);
                if (keyclk_oe || keyinput_oe || !tx_ready || busy) idle_moved = 1'b1;
            end
        end
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_ignores_bus", idle_moved, 0);

        run_frame(8'hED, M_ACK, 1'b0);
        run_frame(8'h07, M_ACK, 1'b0);
        run_frame(8'h00, M_ACK, 1'b0);
        repeat (4) begin
            r = 8'($urandom);
            run_frame(r, M_ACK, 1'b0);
        end
        r = 8'($urandom);
        run_frame(r, M_SILENT, 1'b0);
        r = 8'($urandom);
        run_frame(r, M_NOACK, 1'b0);
        r = 8'($urandom_range(0, 255));
        if (r == 8'hF4) r = 8'h5A;
        run_frame(r, M_ACK, 1'b1);

        r = 8'($urandom) & 8'hEF;
        run_frame(r, M_ABORT, 1'b0);
        check("bit4_driven_before_reset", keyinput_oe, 1);
        #2 rst = 1'b0;
        #1 check("reset_mid_frame", {keyclk_oe, keyinput_oe, tx_ready, busy, tx_done, tx_err}, 6'b001000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(8'hFF, M_ACK, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
